// File: rtl/e_operand_pkg.sv
// Shared encodings for the E-stage operand unit: operand-B source selects
// and the "no forwarding" select value.
package e_operand_pkg;

  localparam logic [1:0] SRC_B_REG   = 2'd0;
  localparam logic [1:0] SRC_B_IMM   = 2'd1;
  localparam logic [1:0] SRC_B_SHAMT = 2'd2;
  localparam logic [1:0] SRC_B_LUI   = 2'd3;

  localparam int unsigned FWD_NONE = 0;

endpackage

// File: rtl/e_fwd_mux.sv
// Combinational forward selector: 0 picks the register value, k picks
// fwd_i slice k-1, and any select above NUM_FWD falls back to the register.
module e_fwd_mux
  import e_operand_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_FWD = 2,
  parameter int FSEL_W  = $clog2(NUM_FWD + 1)
) (
  input  logic [FSEL_W-1:0]        sel_i,
  input  logic [WIDTH-1:0]         reg_i,
  input  logic [NUM_FWD*WIDTH-1:0] fwd_i,
  output logic [WIDTH-1:0]         data_o
);

  // Table covers every select encoding, so out-of-range codes need no guard.
  logic [WIDTH-1:0] src_s [2**FSEL_W];

  for (genvar k = 0; k < 2**FSEL_W; k++) begin : g_src
    if ((k == FWD_NONE) || (k > NUM_FWD)) begin : g_reg
      assign src_s[k] = reg_i;
    end else begin : g_fwd
      assign src_s[k] = fwd_i[k*WIDTH-1 -: WIDTH];
    end
  end

  // Select the resolved operand.
  always_comb begin
    data_o = src_s[sel_i];
  end

endmodule

// File: rtl/e_operand_stage.sv
// E-stage operand unit: forwarding for rs/rt, operand-B source mux and a
// one-deep valid/ready output register with a saturating back-pressure counter.
module e_operand_stage
  import e_operand_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_FWD = 2,
  parameter int FSEL_W  = $clog2(NUM_FWD + 1),
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_rs_data,
  input  logic [WIDTH-1:0]         in_rt_data,
  input  logic [WIDTH-1:0]         in_imm,
  input  logic [4:0]               in_rt,
  input  logic [1:0]               in_src_b,
  input  logic [FSEL_W-1:0]        in_fwd_a,
  input  logic [FSEL_W-1:0]        in_fwd_b,
  input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_a,
  output logic [WIDTH-1:0]         out_b,
  output logic [WIDTH-1:0]         out_rt,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] fa_s, fb_s, b_s, lui_s;
  logic             accept_s;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, rt_q, rt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  e_fwd_mux #(.WIDTH(WIDTH), .NUM_FWD(NUM_FWD), .FSEL_W(FSEL_W)) u_fwd_a (
    .sel_i  (in_fwd_a),
    .reg_i  (in_rs_data),
    .fwd_i  (fwd_data),
    .data_o (fa_s)
  );

  e_fwd_mux #(.WIDTH(WIDTH), .NUM_FWD(NUM_FWD), .FSEL_W(FSEL_W)) u_fwd_b (
    .sel_i  (in_fwd_b),
    .reg_i  (in_rt_data),
    .fwd_i  (fwd_data),
    .data_o (fb_s)
  );

  // Upper immediate lands in bits [31:16]; the cast zero-fills wider datapaths.
  assign lui_s    = WIDTH'({in_imm[15:0], 16'h0000});
  assign in_ready = !valid_q || out_ready;
  assign accept_s = in_valid && in_ready;

  // Operand-B source selection.
  always_comb begin
    b_s = fb_s;
    case (in_src_b)
      SRC_B_REG:   b_s = fb_s;
      SRC_B_IMM:   b_s = in_imm;
      SRC_B_SHAMT: b_s = {{(WIDTH-5){1'b0}}, in_rt};
      SRC_B_LUI:   b_s = lui_s;
      default:     b_s = fb_s;
    endcase
  end

  // Next-state for handshake, operand registers and stall counter.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    rt_d    = rt_q;
    cnt_d   = cnt_q;

    // Flush wins over accept and drops whatever was held.
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d = 1'b1;
      a_d     = fa_s;
      b_d     = b_s;
      rt_d    = fb_s;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (valid_q && !out_ready && !flush && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rt_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rt_q    <= rt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_rt    = rt_q;
  assign stall_cnt = cnt_q;

endmodule
